// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: default payload width, per-boundary payload
// layouts and their all-zero reset values.
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH_DEFAULT = 32;

  // IF/ID: fetched instruction and its PC.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // ID/EX: decoded operands and control.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [5:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  // EX/MEM: ALU result and store data.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  // MEM/WB: write-back value.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  dest;
    logic        reg_wr;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  // Zero payloads used when a stage register is reset.
  localparam logic [PIPE_WIDTH_DEFAULT-1:0] PIPE_PAYLOAD_ZERO = '0;
  localparam if_id_t  IF_ID_ZERO  = '0;
  localparam id_ex_t  ID_EX_ZERO  = '0;
  localparam ex_mem_t EX_MEM_ZERO = '0;
  localparam mem_wb_t MEM_WB_ZERO = '0;

endpackage

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/allowin/readygo handshake.
// DEPTH=1 is a classic single-entry stage; DEPTH>1 is an elastic circular
// buffer. Synchronous flush squashes all entries; reset also zeroes storage.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             allowin,
  input  logic             readygo,
  input  logic             next_allowin,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             allowout,
  input  logic             flush,
  output logic             head_valid,
  output logic [CNTW-1:0]  count
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [PTRW-1:0] LAST_P  = PTRW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wp;
  logic [PTRW-1:0]  r_rp;
  logic [CNTW-1:0]  r_count;

  logic             w_head_valid;
  logic             w_valid_out;
  logic             w_out_fire;
  logic             w_in_fire;
  logic             w_allowin;
  logic [PTRW-1:0]  w_wp_next;
  logic [PTRW-1:0]  w_rp_next;

  // Handshake: flush blocks both directions in its own cycle.
  always_comb begin
    w_head_valid = (r_count != '0);
    w_valid_out  = w_head_valid && readygo && !flush;
    w_out_fire   = w_valid_out && next_allowin;
    w_allowin    = (r_count < DEPTH_C) || w_out_fire;
    w_in_fire    = valid_in && w_allowin && !flush;
  end

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
  always_comb begin
    w_wp_next = (r_wp == LAST_P) ? '0 : r_wp + 1'b1;
    w_rp_next = (r_rp == LAST_P) ? '0 : r_rp + 1'b1;
  end

  // Storage, pointers and occupancy; reset clears everything, flush only
  // rewinds pointers and count and leaves stale payloads in place.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_in_fire) begin
        r_mem[r_wp] <= data_in;
        r_wp        <= w_wp_next;
      end
      if (w_out_fire) begin
        r_rp <= w_rp_next;
      end
      case ({w_in_fire, w_out_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output drive.
  always_comb begin
    allowin    = w_allowin;
    valid_out  = w_valid_out;
    allowout   = w_out_fire;
    head_valid = w_head_valid;
    count      = r_count;
    data_out   = r_mem[r_rp];
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic       clk;
  logic       rst_n;
  logic       vin [3];
  logic [7:0] din [3];
  logic       rg  [3];
  logic       na  [3];
  logic       fl  [3];

  logic       ai_w [3];
  logic       vo_w [3];
  logic [7:0] do_w [3];
  logic       ao_w [3];
  logic       hv_w [3];
  logic [1:0] cnt_w [3];
  logic [0:0] cnt1;
  logic [1:0] cnt2;
  logic [1:0] cnt3;

  assign cnt_w[0] = {1'b0, cnt1};
  assign cnt_w[1] = cnt2;
  assign cnt_w[2] = cnt3;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(rst_n), .valid_in(vin[0]), .data_in(din[0]),
    .allowin(ai_w[0]), .readygo(rg[0]), .next_allowin(na[0]),
    .valid_out(vo_w[0]), .data_out(do_w[0]), .allowout(ao_w[0]),
    .flush(fl[0]), .head_valid(hv_w[0]), .count(cnt1));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(rst_n), .valid_in(vin[1]), .data_in(din[1]),
    .allowin(ai_w[1]), .readygo(rg[1]), .next_allowin(na[1]),
    .valid_out(vo_w[1]), .data_out(do_w[1]), .allowout(ao_w[1]),
    .flush(fl[1]), .head_valid(hv_w[1]), .count(cnt2));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(rst_n), .valid_in(vin[2]), .data_in(din[2]),
    .allowin(ai_w[2]), .readygo(rg[2]), .next_allowin(na[2]),
    .valid_out(vo_w[2]), .data_out(do_w[2]), .allowout(ao_w[2]),
    .flush(fl[2]), .head_valid(hv_w[2]), .count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int         dep  [3] = '{1, 2, 3};
  int         mcnt [3];
  logic       mof  [3];
  logic       minf [3];
  logic [7:0] q    [3][$];

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s inst=D%0d observed=%0h expected=%0h", tag, dep[k], got, exp);
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    logic hv, vo, ai;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      hv      = (mcnt[k] != 0);
      vo      = hv && rg[k] && !fl[k];
      mof[k]  = vo && na[k];
      ai      = (mcnt[k] < dep[k]) || mof[k];
      minf[k] = vin[k] && ai && !fl[k];
      if (rst_n) begin
        chk("head_valid", k, 32'(hv_w[k]), 32'(hv));
        chk("valid_out",  k, 32'(vo_w[k]), 32'(vo));
        chk("allowout",   k, 32'(ao_w[k]), 32'(mof[k]));
        chk("allowin",    k, 32'(ai_w[k]), 32'(ai));
        chk("count",      k, 32'(cnt_w[k]), 32'(mcnt[k]));
        if (hv) chk("data_out", k, 32'(do_w[k]), 32'(q[k][0]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || fl[k]) begin
        mcnt[k] = 0;
        q[k].delete();
        minf[k] = 1'b0;
      end else begin
        if (minf[k]) begin
          q[k].push_back(din[k]);
          mcnt[k]++;
        end
        if (mof[k]) begin
          void'(q[k].pop_front());
          mcnt[k]--;
        end
      end
    end
    #1;
  endtask

  initial begin
    int i;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0; din[k] = 8'h00; rg[k] = 1'b1; na[k] = 1'b1; fl[k] = 1'b0;
      mcnt[k] = 0; mof[k] = 1'b0; minf[k] = 1'b0;
    end

    // Reset: fill D3 first so the reset has entries to discard.
    rst_n = 1'b1;
    tick();
    na[2] = 1'b0; vin[2] = 1'b1; din[2] = 8'h5A;
    tick();
    vin[2] = 1'b0; na[2] = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_data_out", k, 32'(do_w[k]), 32'h0);
      chk("rst_count",    k, 32'(cnt_w[k]), 32'h0);
      chk("rst_allowin",  k, 32'(ai_w[k]), 32'h1);
      chk("rst_valid",    k, 32'(vo_w[k]), 32'h0);
    end

    // DEPTH=1 stream, no bubbles.
    vin[0] = 1'b1; din[0] = 8'h11; tick();
    din[0] = 8'h22; tick();
    chk("d1_stream_valid", 0, 32'(vo_w[0]), 32'h1);
    din[0] = 8'h33; tick();
    vin[0] = 1'b0; tick();
    tick();
    chk("d1_drained", 0, 32'(q[0].size()), 32'h0);

    // DEPTH=1 readygo stall holds the single entry.
    vin[0] = 1'b1; din[0] = 8'h44; rg[0] = 1'b0; tick();
    din[0] = 8'h55; tick();
    tick();
    rg[0] = 1'b1; tick();
    vin[0] = 1'b0; tick();
    tick();

    // DEPTH=2 backpressure.
    na[1] = 1'b0; vin[1] = 1'b1; din[1] = 8'hA0; tick();
    din[1] = 8'hA1; tick();
    din[1] = 8'hA2; tick();
    chk("d2_full_count",   1, 32'(cnt_w[1]), 32'h2);
    chk("d2_full_allowin", 1, 32'(ai_w[1]), 32'h0);
    tick();
    na[1] = 1'b1; tick();
    vin[1] = 1'b0; tick();
    tick();
    tick();
    chk("d2_bp_drained", 1, 32'(q[1].size()), 32'h0);

    // DEPTH=2 full with simultaneous in/out fire.
    na[1] = 1'b0; vin[1] = 1'b1; din[1] = 8'hB0; tick();
    din[1] = 8'hB1; tick();
    na[1] = 1'b1; din[1] = 8'hB2; tick();
    chk("d2_sim_count", 1, 32'(cnt_w[1]), 32'h2);
    vin[1] = 1'b0; tick();
    tick();
    tick();

    // Flush with a full buffer and a same-cycle input.
    na[1] = 1'b0; vin[1] = 1'b1; din[1] = 8'hC0; tick();
    din[1] = 8'hC1; tick();
    din[1] = 8'hC2; na[1] = 1'b1; fl[1] = 1'b1;
    #1;
    chk("flush_valid_out", 1, 32'(vo_w[1]), 32'h0);
    tick();
    fl[1] = 1'b0; vin[1] = 1'b0; tick();
    chk("flush_head_valid", 1, 32'(hv_w[1]), 32'h0);
    vin[1] = 1'b1; din[1] = 8'hD0; tick();
    vin[1] = 1'b0; tick();
    tick();

    // DEPTH=3 wrap with readygo low every other cycle.
    i = 0;
    for (int c = 0; c < 40 && i < 6; c++) begin
      vin[2] = 1'b1; din[2] = 8'hE0 + 8'(i); rg[2] = c[0];
      tick();
      if (minf[2]) i++;
    end
    chk("d3_all_accepted", 2, 32'(i), 32'd6);
    vin[2] = 1'b0;
    for (int c = 0; c < 40 && q[2].size() != 0; c++) begin
      rg[2] = c[0];
      tick();
    end
    chk("d3_drained", 2, 32'(q[2].size()), 32'h0);

    // DEPTH=3 fill to full, then stream through the wrapped pointers.
    rg[2] = 1'b1; na[2] = 1'b0; vin[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      din[2] = 8'hF0 + 8'(c);
      tick();
    end
    chk("d3_full_count", 2, 32'(cnt_w[2]), 32'h3);
    na[2] = 1'b1; din[2] = 8'hF3; tick();
    din[2] = 8'hF4; tick();
    vin[2] = 1'b0;
    for (int c = 0; c < 10 && q[2].size() != 0; c++) tick();
    chk("d3_final_drained", 2, 32'(q[2].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register for the 5-stage MIPS32 core. It replaces the hand-written per-stage valid/allowin/readygo logic and the `pipe_reg` placeholders between the IF/ID, ID/EX, EX/MEM and MEM/WB stages. With DEPTH=1 it behaves exactly like a classic single-entry stage. With DEPTH>1 it becomes an elastic stage: a circular buffer that absorbs downstream stalls. It also provides a synchronous flush for branch and exception squash.

## Interface
Parameters:
- WIDTH, 32, bit width of the payload carried through the stage.
- DEPTH, 1, number of buffered entries; any value ≥1, not required to be a power of two.
- CNTW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-low; clock clk.
- valid_in  input  1  upstream presents a valid payload.
- data_in  input  WIDTH  upstream payload.
- allowin  output  1  stage accepts a payload this cycle.
- readygo  input  1  stage-local logic declares the head entry complete.
- next_allowin  input  1  downstream stage's allowin.
- valid_out  output  1  head entry is valid and ready to leave.
- data_out  output  WIDTH  head entry payload.
- allowout  output  1  head entry leaves this cycle.
- flush  input  1  discard all buffered entries.
- head_valid  output  1  head entry exists; readygo is not considered.
- count  output  CNTW  number of buffered entries.

## Operation
- Fire conditions:
  - in_fire = valid_in && allowin && !flush.
  - out_fire = valid_out && next_allowin.
- Combinational outputs:
  - head_valid = (count != 0).
  - valid_out = head_valid && readygo && !flush.
  - allowout = out_fire.
  - allowin = (count < DEPTH) || out_fire. For DEPTH=1 this reduces to !valid || (readygo && next_allowin).
- Storage: register array mem[DEPTH], write pointer wp, read pointer rp.
  - in_fire writes mem[wp] and advances wp.
  - out_fire advances rp.
  - Each pointer wraps from DEPTH-1 to 0.
- Count update:
  - +1 on in_fire only.
  - -1 on out_fire only.
  - Unchanged when both or neither fire.
- data_out = mem[rp]. It is always driven, and is meaningful only while head_valid.
- Flush (synchronous): next cycle count=0, wp=0, rp=0.
  - Any same-cycle input is dropped.
  - No output fires in the flush cycle.
  - mem contents are not cleared.
- Reset (reset==0 at a clk edge): count=0, wp=0, rp=0, and every mem entry is cleared to 0.
  - Reset overrides flush and both fires.
  - A reset mid-operation discards all entries, in flight or buffered.
- Invariants:
  - Overflow is impossible, because allowin is low when full and no output fires.
  - Underflow is impossible, because valid_out requires head_valid.

## Timing
- Latency: a payload accepted at edge t is at data_out with head_valid=1 in the cycle after t. The earliest it can leave is at edge t+1.
- Throughput: one entry per cycle while readygo and next_allowin are held high, at any DEPTH.
- Combinational paths:
  - next_allowin → allowin.
  - readygo → allowin.
  - flush → valid_out.
  - Chaining stages therefore forms a combinational allowin chain. Timing closure accounts for this.
- Reset values:
  - allowin=1, because count=0.
  - valid_out=0, head_valid=0, allowout=0, count=0.
  - data_out=0.
- Boundary conditions:
  - Full with out_fire: allowin=1, and a simultaneous in_fire keeps count at DEPTH.
  - Empty with valid_in: the entry is accepted, and valid_out stays 0 in that cycle (no bypass).
  - readygo low on the head blocks all later entries (in-order only).
  - Pointer wrap with DEPTH=3: wp takes the sequence 0,1,2,0.

## Structure
- Shared package `pipe_pkg` holds:
  - the default WIDTH constant;
  - the payload typedefs for each boundary: if_id_t, id_ex_t, ex_mem_t, mem_wb_t;
  - the zero reset constant for the payload.
- The top level instantiates one pipe_stage_buf per stage boundary, with WIDTH=$bits of the corresponding typedef.
- No sub-module is needed. Storage is an internal register array, and the pointer wrap logic is local.

## Test plan
- **Reset:** hold reset=0 for 2 cycles, then release. Required: count=0, allowin=1, valid_out=0, data_out=0.
- **DEPTH=1 stream:** data_in=0x11,0x22,0x33 on consecutive cycles, readygo=1, next_allowin=1. Required: data_out of 0x11,0x22,0x33 on the following cycles, one per cycle, with no bubbles.
- **DEPTH=2 backpressure:** next_allowin=0 and push 0xA0,0xA1. Required:
  - count=2 and allowin=0;
  - valid_in of 0xA2 is not accepted;
  - after next_allowin=1, outputs in order 0xA0,0xA1,0xA2.
- **Full plus simultaneous fire, DEPTH=2:** count=2, readygo=1, next_allowin=1, valid_in=1 with 0xB2. Required: 0xB0 leaves, 0xB2 is written, count stays at 2.
- **Flush:** count=2 and valid_in=1 on the same cycle as flush=1. Required:
  - valid_out=0 in that cycle;
  - count=0 on the next cycle, with head_valid=0;
  - the dropped input never appears at data_out.
- **DEPTH=3 wrap plus readygo stall:** push 6 entries through with readygo low every other cycle. Required: all 6 emerge in order, and wp/rp wrap from 2 to 0 with no loss or duplication.
